// File: rtl/bit_pattern_serializer_pkg.sv
// Shared definitions for the bit-pattern serializer: state encoding,
// default geometry and the load-length clamp helper.
package ser_pkg;

    localparam int DEF_WIDTH      = 11;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_GAP_CYCLES = 2;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_GAP   = ENC_GAP
    } state_t;

    // A zero or oversized length means "send the whole word".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/bit_pattern_serializer.sv
// Parallel-to-serial stimulus stage: accepts a word over valid/ready and
// shifts it out MSB-first, one bit per clk, with back-to-back words streaming
// without a bubble. Defining SER_GAP_EN inserts GAP_CYCLES idle cycles after
// every word; without it GAP_CYCLES is only range-checked.
//
// state | meaning
// IDLE  | nothing in flight, ready for a word
// SHIFT | a payload bit is on ser_out; cnt counts bits remaining after it
// GAP   | inter-word idle time (SER_GAP_EN builds only)
module bit_pattern_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2) begin : g_bad_width
        $error("bit_pattern_serializer: WIDTH must be at least 2");
    end
    if ((1 << LEN_W) <= WIDTH) begin : g_bad_len_w
        $error("bit_pattern_serializer: LEN_W too narrow for WIDTH");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("bit_pattern_serializer: GAP_CYCLES must be at least 1");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] len_c;
    logic [WIDTH-1:0] load_shreg;
    logic             accept;
    logic             done_n;
    logic             load_ready_n;

`ifdef SER_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
`endif

    // Shifted-out positions fill with zeros, so once a word has left the
    // register its MSB is 0 and ser_out needs no state gating.
    assign ser_out = shreg[WIDTH-1];

    // Next-state, datapath and output decode for the following cycle.
    always_comb begin
        accept     = load_valid & load_ready;
        len_c      = LEN_W'(clamp_len(32'(load_len), WIDTH));
        load_shreg = load_data << (WIDTH - int'(len_c));
        state_n    = state;
        shreg_n    = shreg;
        cnt_n      = cnt;
`ifdef SER_GAP_EN
        gap_cnt_n  = gap_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SHIFT;
                    shreg_n = load_shreg;
                    cnt_n   = len_c - 1'b1;
                end
            end
            ST_SHIFT: begin
                shreg_n = shreg << 1;
                cnt_n   = cnt - 1'b1;
                if (cnt == '0) begin
`ifdef SER_GAP_EN
                    state_n   = ST_GAP;
                    cnt_n     = '0;
                    gap_cnt_n = GAP_W'(GAP_CYCLES - 1);
`else
                    if (accept) begin
                        shreg_n = load_shreg;
                        cnt_n   = len_c - 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
`endif
                end
            end
`ifdef SER_GAP_EN
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    if (accept) begin
                        state_n = ST_SHIFT;
                        shreg_n = load_shreg;
                        cnt_n   = len_c - 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                shreg_n = '0;
                cnt_n   = '0;
            end
        endcase

        done_n = (state_n == ST_SHIFT) && (cnt_n == '0);
`ifdef SER_GAP_EN
        load_ready_n = (state_n == ST_IDLE) || ((state_n == ST_GAP) && (gap_cnt_n == '0));
`else
        load_ready_n = (state_n == ST_IDLE) || done_n;
`endif
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef SER_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            ser_valid  <= (state_n == ST_SHIFT);
            busy       <= (state_n != ST_IDLE);
            done       <= done_n;
            load_ready <= load_ready_n;
`ifdef SER_GAP_EN
            gap_cnt    <= gap_cnt_n;
`endif
        end
    end

endmodule
